// File: rtl/pc_ctrl_seq_if.sv
// Fetch-head control bus: decode drives the branch/stall/halt requests,
// the PC controller returns the PC, flush pulse, halt status and taken counter.
interface pc_ctrl_seq_if #(
  parameter int PC_W  = 16,
  parameter int OFF_W = 9,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             halt;
  logic             br;
  logic             br_reg;
  logic [2:0]       C;
  logic [OFF_W-1:0] I;
  logic [2:0]       F;
  logic [PC_W-1:0]  reg_target;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output stall, halt, br, br_reg, C, I, F, reg_target,
    input  pc, pc_plus, flush, halted, taken_cnt
  );

  modport slave (
    input  stall, halt, br, br_reg, C, I, F, reg_target,
    output pc, pc_plus, flush, halted, taken_cnt
  );
endinterface

// File: rtl/pc_ctrl_seq.sv
// Registered program-counter controller: branch-condition evaluation, relative and
// register-indirect redirects, stall/halt handling, flush pulse and taken counter.
module pc_ctrl_seq #(
  parameter int PC_W     = 16,
  parameter int OFF_W    = 9,
  parameter int INC      = 2,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  pc_ctrl_seq_if.slave bus
);

  typedef enum logic {RUN, HALTED} state_t;

  function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000:  cond_eval = !z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = !z && !n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z || (!z && !n);
      3'b101:  cond_eval = n || z;
      3'b110:  cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Offset is in instruction words; scale to bytes and wrap modulo 2^PC_W.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] base,
                                                 input logic [OFF_W-1:0] off);
    logic signed [OFF_W-1:0] off_s;
    logic signed [PC_W-1:0]  off_ext;
    off_s      = off;
    off_ext    = PC_W'(off_s);
    rel_target = base + (off_ext <<< 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + CNT_W'(1);
  endfunction

  state_t            state_p0, state_nxt;
  logic [PC_W-1:0]   pc_p0, pc_nxt;
  logic              flush_p0, flush_nxt;
  logic [CNT_W-1:0]  cnt_p0, cnt_nxt;
  logic [PC_W-1:0]   pc_plus;
  logic [PC_W-1:0]   target;
  logic              cond_ok;
  logic              taken;

  assign pc_plus = pc_p0 + PC_W'(INC);
  assign cond_ok = cond_eval(bus.C, bus.F);
  assign taken   = (bus.br || bus.br_reg) && cond_ok;
  assign target  = bus.br_reg ? bus.reg_target : rel_target(pc_plus, bus.I);

  // Stage p0: next-state decision from current state and decode inputs
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    flush_nxt = 1'b0;
    cnt_nxt   = cnt_p0;
    case (state_p0)
      RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            state_nxt = HALTED;
          end else if (taken) begin
            pc_nxt    = target;
            flush_nxt = 1'b1;
            cnt_nxt   = sat_inc(cnt_p0);
          end else begin
            pc_nxt = pc_plus;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= RUN;
      pc_p0    <= PC_W'(RESET_PC);
      flush_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      flush_p0 <= flush_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign bus.pc        = pc_p0;
  assign bus.pc_plus   = pc_plus;
  assign bus.flush     = flush_p0;
  assign bus.halted    = (state_p0 == HALTED);
  assign bus.taken_cnt = cnt_p0;

endmodule

// File: tb/tb_pc_ctrl_seq.sv
// Directed bench for pc_ctrl_seq: reset, condition sweep, offset wrap,
// register branch, stall/halt priority and counter saturation.
module tb_pc_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_ctrl_seq_if #(.PC_W(16), .OFF_W(9), .CNT_W(16)) m_if ();
  pc_ctrl_seq_if #(.PC_W(16), .OFF_W(9), .CNT_W(2))  s_if ();

  pc_ctrl_seq #(.PC_W(16), .OFF_W(9), .INC(2), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave)
  );
  pc_ctrl_seq #(.PC_W(16), .OFF_W(9), .INC(2), .RESET_PC(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(s_if.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Taken pattern per condition code, bit f set when F=f should take the branch.
  logic [7:0] tk_tbl [8] = '{8'h0F, 8'hF0, 8'h05, 8'hAA, 8'hF5, 8'hFA, 8'hCC, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    m_if.stall = 0; m_if.halt = 0; m_if.br = 0; m_if.br_reg = 0;
    m_if.C = 3'd0; m_if.I = 9'd0; m_if.F = 3'd0; m_if.reg_target = 16'd0;
    s_if.stall = 0; s_if.halt = 0; s_if.br = 0; s_if.br_reg = 0;
    s_if.C = 3'd0; s_if.I = 9'd0; s_if.F = 3'd0; s_if.reg_target = 16'd0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic tk;
    clr_in();
    do_reset();
    chk("rst_pc", 32'(m_if.pc), 32'h0);
    chk("rst_flush", 32'(m_if.flush), 32'h0);
    chk("rst_halted", 32'(m_if.halted), 32'h0);
    chk("rst_cnt", 32'(m_if.taken_cnt), 32'h0);

    step(); chk("idle_pc1", 32'(m_if.pc), 32'h2);
    step(); chk("idle_pc2", 32'(m_if.pc), 32'h4);
    step(); chk("idle_pc3", 32'(m_if.pc), 32'h6);
    chk("idle_flush", 32'(m_if.flush), 32'h0);
    chk("idle_cnt", 32'(m_if.taken_cnt), 32'h0);
    chk("idle_pc_plus", 32'(m_if.pc_plus), 32'h8);

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        do_reset();
        m_if.br_reg = 1; m_if.C = 3'b111; m_if.reg_target = 16'h0010;
        step();
        m_if.br_reg = 0; m_if.br = 1; m_if.C = 3'(c); m_if.F = 3'(f); m_if.I = 9'h004;
        step();
        clr_in();
        tk = tk_tbl[c][f];
        chk($sformatf("sweep_pc c%0d f%0d", c, f), 32'(m_if.pc), tk ? 32'h1A : 32'h12);
        chk($sformatf("sweep_flush c%0d f%0d", c, f), 32'(m_if.flush), 32'(tk));
        if (tk) begin
          step();
          chk($sformatf("sweep_flush_drop c%0d f%0d", c, f), 32'(m_if.flush), 32'h0);
          chk($sformatf("sweep_pc_after c%0d f%0d", c, f), 32'(m_if.pc), 32'h1C);
        end
      end
    end

    do_reset();
    m_if.br = 1; m_if.C = 3'b111; m_if.I = 9'h1FF;
    step(); clr_in();
    chk("neg_pc", 32'(m_if.pc), 32'h0);
    chk("neg_flush", 32'(m_if.flush), 32'h1);
    chk("neg_cnt", 32'(m_if.taken_cnt), 32'h1);
    m_if.br_reg = 1; m_if.C = 3'b111; m_if.reg_target = 16'hFFFE;
    step(); clr_in();
    chk("wrap_setup", 32'(m_if.pc), 32'hFFFE);
    chk("wrap_pc_plus", 32'(m_if.pc_plus), 32'h0);
    step();
    chk("wrap_pc", 32'(m_if.pc), 32'h0);

    do_reset();
    m_if.br = 1; m_if.br_reg = 1; m_if.reg_target = 16'h1234; m_if.C = 3'b111; m_if.I = 9'h004;
    step();
    chk("both_pc", 32'(m_if.pc), 32'h1234);
    chk("both_cnt", 32'(m_if.taken_cnt), 32'h1);
    m_if.br_reg = 0; m_if.stall = 1;
    step();
    chk("stall_pc", 32'(m_if.pc), 32'h1234);
    chk("stall_flush", 32'(m_if.flush), 32'h0);
    chk("stall_cnt", 32'(m_if.taken_cnt), 32'h1);
    m_if.halt = 1;
    step();
    chk("stall_halt_pc", 32'(m_if.pc), 32'h1234);
    chk("stall_halt_halted", 32'(m_if.halted), 32'h0);
    m_if.halt = 0; m_if.stall = 0;
    step();
    chk("unstall_pc", 32'(m_if.pc), 32'h123E);
    chk("unstall_flush", 32'(m_if.flush), 32'h1);
    chk("unstall_cnt", 32'(m_if.taken_cnt), 32'h2);

    m_if.halt = 1;
    step();
    chk("halt_pc", 32'(m_if.pc), 32'h123E);
    chk("halt_halted", 32'(m_if.halted), 32'h1);
    chk("halt_flush", 32'(m_if.flush), 32'h0);
    chk("halt_cnt", 32'(m_if.taken_cnt), 32'h2);
    m_if.halt = 0;
    step(); step();
    chk("halted_pc", 32'(m_if.pc), 32'h123E);
    chk("halted_still", 32'(m_if.halted), 32'h1);
    chk("halted_cnt", 32'(m_if.taken_cnt), 32'h2);
    chk("halted_flush", 32'(m_if.flush), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_rst_pc", 32'(m_if.pc), 32'h0);
    chk("halt_rst_halted", 32'(m_if.halted), 32'h0);
    chk("halt_rst_cnt", 32'(m_if.taken_cnt), 32'h0);
    clr_in();
    step();
    chk("post_halt_pc", 32'(m_if.pc), 32'h2);

    m_if.stall = 1;
    step();
    chk("stall_hold", 32'(m_if.pc), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stall_rst_pc", 32'(m_if.pc), 32'h0);

    do_reset();
    s_if.br = 1; s_if.C = 3'b111; s_if.I = 9'h000;
    step(); chk("sat_cnt1", 32'(s_if.taken_cnt), 32'd1);
    step(); chk("sat_cnt2", 32'(s_if.taken_cnt), 32'd2);
    step(); chk("sat_cnt3", 32'(s_if.taken_cnt), 32'd3);
    step(); chk("sat_cnt4", 32'(s_if.taken_cnt), 32'd3);
    chk("sat_flush_b2b", 32'(s_if.flush), 32'h1);
    step(); chk("sat_cnt5", 32'(s_if.taken_cnt), 32'd3);
    chk("sat_pc", 32'(s_if.pc), 32'hA);
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
